// File: rtl/cmd_rd53_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rd53_deser_if
// Description : Bundles the serial input side and the framed output side of
//               the RD53 command deserializer. The master modport drives the
//               serial stream, and the slave modport is the deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmd_rd53_deser_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 cmd_serial_in;
  logic                 serial_val;
  logic [15:0]          frame_data;
  logic                 frame_valid;
  logic                 frame_is_sync;
  logic                 locked;
  logic                 lost_lock;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] lock_loss_cnt;

  // Stream source / frame monitor side
  modport master (
    output cmd_serial_in,
    output serial_val,
    input  frame_data,
    input  frame_valid,
    input  frame_is_sync,
    input  locked,
    input  lost_lock,
    input  frame_cnt,
    input  lock_loss_cnt
  );

  // Deserializer side
  modport slave (
    input  cmd_serial_in,
    input  serial_val,
    output frame_data,
    output frame_valid,
    output frame_is_sync,
    output locked,
    output lost_lock,
    output frame_cnt,
    output lock_loss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cmd_rd53_deser.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rd53_deser
// Description : RD53 command stream receiver. The module hunts for the sync
//               frame at any bit alignment, then confirms it on consecutive
//               frame boundaries, and locks. While locked, it emits every
//               aligned 16-bit frame in parallel. Lock drops after a run of
//               non-sync frames.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_rd53_deser #(
  parameter logic [15:0] SYNC_WORD     = 16'h817E,
  parameter int          LOCK_SYNCS    = 4,
  parameter int          UNLOCK_FRAMES = 32,
  parameter int          CNT_WIDTH     = 8
) (
  input  wire logic        cmd_clk,
  input  wire logic        rst_n,
  cmd_rd53_deser_if.slave  bus
);

  localparam logic [1:0]  c_st_hunt    = 2'd0;
  localparam logic [1:0]  c_st_verify  = 2'd1;
  localparam logic [1:0]  c_st_locked  = 2'd2;
  localparam logic [3:0]  c_lock_syncs = 4'(LOCK_SYNCS);
  localparam logic [15:0] c_unlock     = 16'(UNLOCK_FRAMES);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  // FSM state
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;

  // Alignment datapath
  logic [15:0]          r_sr;
  logic [3:0]           r_bit_cnt;
  logic [3:0]           r_sync_cnt;
  logic [15:0]          r_nosync_cnt;

  // Registered outputs
  logic [15:0]          r_frame_data;
  logic                 r_frame_valid;
  logic                 r_frame_is_sync;
  logic                 r_locked;
  logic                 r_lost_lock;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [CNT_WIDTH-1:0] r_lock_loss_cnt;

  // Per-edge decode
  logic [15:0]          w_word;
  logic                 w_samp;
  logic                 w_match;
  logic                 w_boundary;
  logic [3:0]           w_sync_inc;
  logic [15:0]          w_nosync_inc;

  // Next-value / action signals produced by the output decode
  logic                 w_emit;
  logic                 w_lose;
  logic [3:0]           w_bit_cnt_nxt;
  logic [3:0]           w_sync_cnt_nxt;
  logic [15:0]          w_nosync_nxt;

  // The word under test always includes the bit arriving on this edge.
  assign w_samp       = bus.serial_val;
  assign w_word       = {r_sr[14:0], bus.cmd_serial_in};
  assign w_match      = (w_word == SYNC_WORD);
  assign w_boundary   = w_samp && (r_bit_cnt == 4'd15);
  assign w_sync_inc   = r_sync_cnt + 4'd1;
  assign w_nosync_inc = r_nosync_cnt + 16'd1;

  // State register
  always_ff @(posedge cmd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_hunt;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: sliding search in HUNT, boundary-only checks elsewhere
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_hunt: begin
        if (w_samp && w_match) begin
          w_state_nxt = (c_lock_syncs == 4'd1) ? c_st_locked : c_st_verify;
        end
      end
      c_st_verify: begin
        if (w_boundary) begin
          if (!w_match) begin
            w_state_nxt = c_st_hunt;
          end else if (w_sync_inc == c_lock_syncs) begin
            w_state_nxt = c_st_locked;
          end
        end
      end
      c_st_locked: begin
        if (w_boundary && !w_match && (w_nosync_inc == c_unlock)) begin
          w_state_nxt = c_st_hunt;
        end
      end
      default: w_state_nxt = c_st_hunt;
    endcase
  end

  // Output/action decode: frame emission, lock loss and counter next values
  always_comb begin
    w_emit         = 1'b0;
    w_lose         = 1'b0;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_sync_cnt_nxt = r_sync_cnt;
    w_nosync_nxt   = r_nosync_cnt;

    if (w_samp) begin
      w_bit_cnt_nxt = r_bit_cnt + 4'd1;
    end

    case (r_state)
      c_st_hunt: begin
        if (w_samp && w_match) begin
          // The sync just found defines the frame alignment from here on.
          w_bit_cnt_nxt  = 4'd0;
          w_sync_cnt_nxt = 4'd1;
          w_nosync_nxt   = 16'd0;
        end
      end
      c_st_verify: begin
        if (w_boundary) begin
          if (w_match) begin
            w_sync_cnt_nxt = w_sync_inc;
            w_nosync_nxt   = 16'd0;
          end else begin
            w_sync_cnt_nxt = 4'd0;
          end
        end
      end
      c_st_locked: begin
        if (w_boundary) begin
          if (w_match) begin
            w_nosync_nxt = 16'd0;
            w_emit       = 1'b1;
          end else if (w_nosync_inc == c_unlock) begin
            // Cleared so a later relock starts its miss run from zero.
            w_nosync_nxt   = 16'd0;
            w_sync_cnt_nxt = 4'd0;
            w_lose         = 1'b1;
          end else begin
            w_nosync_nxt = w_nosync_inc;
            w_emit       = 1'b1;
          end
        end
      end
      default: begin
        w_sync_cnt_nxt = 4'd0;
        w_nosync_nxt   = 16'd0;
      end
    endcase
  end

  // Alignment datapath registers; everything holds when no bit is qualified
  always_ff @(posedge cmd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr         <= 16'd0;
      r_bit_cnt    <= 4'd0;
      r_sync_cnt   <= 4'd0;
      r_nosync_cnt <= 16'd0;
    end else begin
      if (w_samp) begin
        r_sr <= w_word;
      end
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_sync_cnt   <= w_sync_cnt_nxt;
      r_nosync_cnt <= w_nosync_nxt;
    end
  end

  // Output registers: pulses last one cycle, data and counters are held
  always_ff @(posedge cmd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data    <= 16'd0;
      r_frame_valid   <= 1'b0;
      r_frame_is_sync <= 1'b0;
      r_locked        <= 1'b0;
      r_lost_lock     <= 1'b0;
      r_frame_cnt     <= '0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_frame_valid   <= w_emit;
      r_frame_is_sync <= w_emit && w_match;
      r_lost_lock     <= w_lose;
      // Taken from the next state so LOCKED falls with the LOST_LOCK pulse.
      r_locked        <= (w_state_nxt == c_st_locked);
      if (w_emit) begin
        r_frame_data <= w_word;
        r_frame_cnt  <= r_frame_cnt + 1'b1;
      end
      if (w_lose && (r_lock_loss_cnt != c_cnt_max)) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
      end
    end
  end

  assign bus.frame_data    = r_frame_data;
  assign bus.frame_valid   = r_frame_valid;
  assign bus.frame_is_sync = r_frame_is_sync;
  assign bus.locked        = r_locked;
  assign bus.lost_lock     = r_lost_lock;
  assign bus.frame_cnt     = r_frame_cnt;
  assign bus.lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmd_rd53_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_rd53_deser
// Description : Self-checking bench for cmd_rd53_deser. The bench applies
//               directed scenarios and then a randomized stream. It compares
//               the DUT outputs every cycle against a bit-level behavioural
//               model of the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_rd53_deser;

  localparam int          CW      = 8;
  localparam logic [15:0] SYNC    = 16'h817E;
  localparam int          NLOCK   = 4;
  localparam int          NUNLOCK = 32;
  localparam int          CMAX    = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cmd_rd53_deser_if #(.CNT_WIDTH(CW)) bus ();

  cmd_rd53_deser #(
    .SYNC_WORD     (SYNC),
    .LOCK_SYNCS    (NLOCK),
    .UNLOCK_FRAMES (NUNLOCK),
    .CNT_WIDTH     (CW)
  ) dut (
    .cmd_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Comparison helper
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: receiver progress is expressed as how many syncs have
  // been seen, how many misses have occurred in a row, and the bit position
  // within the current frame.
  int          m_mode;      // 0 searching, 1 confirming, 2 locked
  int          m_phase;     // bits since frame start, modulo 16
  int          m_syncs;
  int          m_misses;
  logic [15:0] m_hist;

  logic [15:0] e_data;
  logic        e_valid, e_sync, e_locked, e_lost;
  int          e_fcnt, e_llc;

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_syncs = 0; m_misses = 0; m_hist = 16'd0;
    e_data = 16'd0; e_valid = 1'b0; e_sync = 1'b0; e_locked = 1'b0;
    e_lost = 1'b0; e_fcnt = 0; e_llc = 0;
  endfunction

  function automatic void model_emit(input logic s);
    e_valid = 1'b1;
    e_sync  = s;
    e_data  = m_hist;
    e_fcnt  = (e_fcnt + 1) % (CMAX + 1);
  endfunction

  function automatic void model_bit(input logic b);
    logic at_end;
    logic is_sync;
    m_hist  = {m_hist[14:0], b};
    is_sync = (m_hist == SYNC);
    at_end  = (m_phase == 15);
    m_phase = (m_phase + 1) % 16;
    case (m_mode)
      0: if (is_sync) begin
           m_phase = 0; m_syncs = 1; m_misses = 0;
           m_mode  = (NLOCK == 1) ? 2 : 1;
         end
      1: if (at_end) begin
           if (is_sync) begin
             m_syncs++;
             if (m_syncs == NLOCK) begin m_mode = 2; m_misses = 0; end
           end else begin
             m_mode = 0; m_syncs = 0;
           end
         end
      default: if (at_end) begin
           if (is_sync) begin
             m_misses = 0;
             model_emit(1'b1);
           end else begin
             m_misses++;
             if (m_misses == NUNLOCK) begin
               m_mode = 0; m_syncs = 0; m_misses = 0; e_lost = 1'b1;
               if (e_llc < CMAX) e_llc++;
             end else begin
               model_emit(1'b0);
             end
           end
         end
    endcase
    e_locked = (m_mode == 2);
  endfunction

  task automatic check_outputs();
    check_eq("frame_valid",   32'(bus.frame_valid),   32'(e_valid));
    check_eq("frame_is_sync", 32'(bus.frame_is_sync), 32'(e_sync));
    check_eq("frame_data",    32'(bus.frame_data),    32'(e_data));
    check_eq("locked",        32'(bus.locked),        32'(e_locked));
    check_eq("lost_lock",     32'(bus.lost_lock),     32'(e_lost));
    check_eq("frame_cnt",     32'(bus.frame_cnt),     32'(e_fcnt));
    check_eq("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(e_llc));
  endtask

  // One clock: drive on the falling edge, then model and check after the rising edge
  task automatic step(input logic b, input logic v);
    @(negedge clk);
    bus.cmd_serial_in = b;
    bus.serial_val    = v;
    @(posedge clk);
    e_valid = 1'b0; e_sync = 1'b0; e_lost = 1'b0;
    if (v) model_bit(b);
    #1;
    check_outputs();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) step(w[i], 1'b1);
  endtask

  task automatic send_word_gappy(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      step(w[i], 1'b1);
      step(1'($urandom), 1'b0);
    end
  endtask

  // Asynchronous reset applied between clock edges, checked before the next edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.serial_val = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_nonsync();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == SYNC) w = w ^ 16'h0001;
    return w;
  endfunction

  initial begin
    bus.cmd_serial_in = 1'b0;
    bus.serial_val    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Acquire lock on five syncs; the fifth is the first frame emitted
    repeat (5) send_word(SYNC);
    check_eq("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check_eq("t1_frame_data", 32'(bus.frame_data), 32'h817E);
    check_eq("t1_locked", 32'(bus.locked), 32'd1);

    // Mixed frames while locked
    send_word(16'h6A6A);
    check_eq("t2_data0", 32'(bus.frame_data), 32'h6A6A);
    send_word(SYNC);
    send_word(16'hA5A5);
    check_eq("t2_data2", 32'(bus.frame_data), 32'hA5A5);

    // Clear the miss run, then 32 non-sync frames: 31 emitted, then lock lost
    send_word(SYNC);
    repeat (NUNLOCK) send_word(16'h6A6A);
    check_eq("t4_frame_cnt", 32'(bus.frame_cnt), 32'd36);
    check_eq("t4_lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'd1);
    check_eq("t4_locked", 32'(bus.locked), 32'd0);

    // Relock at a 3-bit offset
    repeat (3) step(1'b0, 1'b1);
    repeat (4) send_word(SYNC);
    send_word(16'h1234);
    check_eq("t3_data", 32'(bus.frame_data), 32'h1234);

    // Reset mid-frame while outputs are nonzero
    for (int i = 15; i >= 9; i--) step(SYNC[i], 1'b1);
    do_reset();

    // VERIFY broken by a non-sync boundary, then a fresh lock
    repeat (2) send_word(SYNC);
    send_word(16'h1234);
    repeat (5) send_word(SYNC);
    check_eq("t5_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Qualifier toggling every cycle while locking and receiving
    do_reset();
    repeat (5) send_word_gappy(SYNC);
    send_word_gappy(16'hC3C3);
    send_word_gappy(16'h0F0F);
    check_eq("t6_data", 32'(bus.frame_data), 32'h0F0F);
    check_eq("t6_frame_cnt", 32'(bus.frame_cnt), 32'd3);

    // Randomized stream with qualifier gaps, junk bits and miss bursts
    for (int n = 0; n < 160; n++) begin
      logic [15:0] w;
      if (n % 60 == 30) begin
        for (int k = 0; k < NUNLOCK + 2; k++) send_word(rand_nonsync());
      end
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 15)); k++)
          step(1'($urandom), 1'b1);
      end
      w = ($urandom_range(0, 9) < 5) ? SYNC : rand_nonsync();
      for (int i = 15; i >= 0; i--) begin
        while ($urandom_range(0, 3) == 0) step(1'($urandom), 1'b0);
        step(w[i], 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
